// File: rtl/push_packer_pkg.sv
// Common constants helpers for the push-packer slice.
// Provides a clog2 that never returns zero, so single-entry counters still get one bit.
package push_packer_pkg;

    function automatic int unsigned clog2_min1(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(value)) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/push_packer.sv
// Packs RATIO narrow samples into one wide word and pushes it to the downstream FIFO.
// Whole words are dropped (and counted) when the FIFO reports almost-full at word start.
module push_packer
    import push_packer_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = 8,
    parameter int unsigned RATIO     = 4,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                         wclock,
    input  logic                         resetn,
    input  logic [IN_WIDTH-1:0]          sdata,
    input  logic                         senable,
    input  logic                         sfirst,
    input  logic                         iafull,
    output logic [RATIO*IN_WIDTH-1:0]    odata,
    output logic                         ogap,
    output logic                         oenable,
    output logic [CNT_WIDTH-1:0]         dropped
);

    localparam int unsigned LaneW = clog2_min1(RATIO);
    localparam int unsigned OutW  = RATIO * IN_WIDTH;
    localparam logic [LaneW-1:0] LastLane = LaneW'(RATIO - 1);

    logic [LaneW-1:0]     lane_q, lane_d;
    logic                 keep_q, keep_d;
    logic                 gap_pend_q, gap_pend_d;
    logic [OutW-1:0]      asm_q, asm_d;
    logic [OutW-1:0]      odata_q, odata_d;
    logic                 ogap_q, ogap_d;
    logic                 oenable_q, oenable_d;
    logic [CNT_WIDTH-1:0] dropped_q, dropped_d;

    logic                 word_start;
    logic                 keep_eff;
    logic                 drop_word;
    logic [LaneW-1:0]     eff_lane;
    logic [OutW-1:0]      word_next;

    always_comb begin
        lane_d     = lane_q;
        keep_d     = keep_q;
        gap_pend_d = gap_pend_q;
        asm_d      = asm_q;
        odata_d    = odata_q;
        ogap_d     = ogap_q;
        oenable_d  = 1'b0;
        word_start = 1'b0;
        keep_eff   = keep_q;
        drop_word  = 1'b0;
        eff_lane   = lane_q;
        word_next  = asm_q;

        if (senable) begin
            word_start = (lane_q == '0) || sfirst;
            eff_lane   = word_start ? '0 : lane_q;
            keep_eff   = word_start ? !iafull : keep_q;

            for (int k = 0; k < int'(RATIO); k++) begin
                if (eff_lane == LaneW'(k)) begin
                    word_next[k*IN_WIDTH +: IN_WIDTH] = sdata;
                end
            end
            asm_d  = word_next;
            keep_d = keep_eff;

            // Realign abandons the partial word; it can never coincide with word end.
            if (sfirst && (lane_q != '0)) begin
                drop_word  = 1'b1;
                gap_pend_d = 1'b1;
            end

            if (eff_lane == LastLane) begin
                lane_d = '0;
                if (keep_eff) begin
                    oenable_d  = 1'b1;
                    odata_d    = word_next;
                    ogap_d     = gap_pend_q;
                    gap_pend_d = 1'b0;
                end else begin
                    drop_word  = 1'b1;
                    gap_pend_d = 1'b1;
                end
            end else begin
                lane_d = eff_lane + 1'b1;
            end
        end

        dropped_d = dropped_q;
        if (drop_word && (dropped_q != '1)) begin
            dropped_d = dropped_q + 1'b1;
        end
    end

    always_ff @(posedge wclock or negedge resetn) begin
        if (!resetn) begin
            lane_q     <= '0;
            keep_q     <= 1'b0;
            gap_pend_q <= 1'b0;
            asm_q      <= '0;
            odata_q    <= '0;
            ogap_q     <= 1'b0;
            oenable_q  <= 1'b0;
            dropped_q  <= '0;
        end else begin
            lane_q     <= lane_d;
            keep_q     <= keep_d;
            gap_pend_q <= gap_pend_d;
            asm_q      <= asm_d;
            odata_q    <= odata_d;
            ogap_q     <= ogap_d;
            oenable_q  <= oenable_d;
            dropped_q  <= dropped_d;
        end
    end

    assign odata   = odata_q;
    assign ogap    = ogap_q;
    assign oenable = oenable_q;
    assign dropped = dropped_q;

endmodule

// File: tb/tb_push_packer.sv
// Directed bench for push_packer: default instance plus a 2-bit-counter instance
// sharing the same stimulus for the saturation case.
module tb_push_packer;

    logic        wclock;
    logic        resetn;
    logic [7:0]  sdata;
    logic        senable;
    logic        sfirst;
    logic        iafull;

    logic [31:0] odata;
    logic        ogap;
    logic        oenable;
    logic [15:0] dropped;

    logic [31:0] s_odata;
    logic        s_ogap;
    logic        s_oenable;
    logic [1:0]  s_dropped;

    int checks;
    int failures;

    push_packer #(.IN_WIDTH(8), .RATIO(4), .CNT_WIDTH(16)) dut (
        .wclock  (wclock),
        .resetn  (resetn),
        .sdata   (sdata),
        .senable (senable),
        .sfirst  (sfirst),
        .iafull  (iafull),
        .odata   (odata),
        .ogap    (ogap),
        .oenable (oenable),
        .dropped (dropped)
    );

    push_packer #(.IN_WIDTH(8), .RATIO(4), .CNT_WIDTH(2)) dut_sat (
        .wclock  (wclock),
        .resetn  (resetn),
        .sdata   (sdata),
        .senable (senable),
        .sfirst  (sfirst),
        .iafull  (iafull),
        .odata   (s_odata),
        .ogap    (s_ogap),
        .oenable (s_oenable),
        .dropped (s_dropped)
    );

    initial wclock = 1'b0;
    always #5 wclock = ~wclock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock with the given inputs; outputs are sampled 1ns after the edge.
    task automatic step(input logic en, input logic [7:0] d, input logic first, input logic af);
        senable = en;
        sdata   = d;
        sfirst  = first;
        iafull  = af;
        @(posedge wclock);
        #1;
        senable = 1'b0;
        sfirst  = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 8'h00, 1'b0, iafull);
    endtask

    task automatic word(input logic [31:0] w, input logic af_first);
        step(1'b1, w[7:0],   1'b0, af_first);
        step(1'b1, w[15:8],  1'b0, 1'b0);
        step(1'b1, w[23:16], 1'b0, 1'b0);
        step(1'b1, w[31:24], 1'b0, 1'b0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        resetn   = 1'b0;
        sdata    = 8'h00;
        senable  = 1'b0;
        sfirst   = 1'b0;
        iafull   = 1'b0;
        repeat (2) @(posedge wclock);
        #1;
        check("rst_odata", 64'(odata), 64'h0);
        check("rst_ogap", 64'(ogap), 64'h0);
        check("rst_oenable", 64'(oenable), 64'h0);
        check("rst_dropped", 64'(dropped), 64'h0);
        resetn = 1'b1;
        idle();

        // Back-to-back word.
        step(1'b1, 8'h11, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b0, 1'b0);
        step(1'b1, 8'h33, 1'b0, 1'b0);
        check("b2b_no_early_push", 64'(oenable), 64'h0);
        step(1'b1, 8'h44, 1'b0, 1'b0);
        check("b2b_oenable", 64'(oenable), 64'h1);
        check("b2b_odata", 64'(odata), 64'h44332211);
        check("b2b_ogap", 64'(ogap), 64'h0);
        check("b2b_dropped", 64'(dropped), 64'h0);
        idle();
        check("b2b_pulse_single", 64'(oenable), 64'h0);

        // Same word with idle gaps.
        step(1'b1, 8'h11, 1'b0, 1'b0);
        idle();
        step(1'b1, 8'h22, 1'b0, 1'b0);
        idle();
        idle();
        step(1'b1, 8'h33, 1'b0, 1'b0);
        idle();
        check("gap_no_early_push", 64'(oenable), 64'h0);
        step(1'b1, 8'h44, 1'b0, 1'b0);
        check("gap_oenable", 64'(oenable), 64'h1);
        check("gap_odata", 64'(odata), 64'h44332211);
        idle();

        // Almost-full at word start drops the word; mid-word deassert ignored.
        word(32'h04030201, 1'b1);
        check("af_no_push", 64'(oenable), 64'h0);
        check("af_dropped", 64'(dropped), 64'h1);
        word(32'hDDCCBBAA, 1'b0);
        check("af_next_push", 64'(oenable), 64'h1);
        check("af_next_odata", 64'(odata), 64'hDDCCBBAA);
        check("af_next_ogap", 64'(ogap), 64'h1);
        word(32'h88776655, 1'b0);
        check("af_after_odata", 64'(odata), 64'h88776655);
        check("af_after_ogap", 64'(ogap), 64'h0);
        idle();

        // Realign mid-word.
        step(1'b1, 8'h01, 1'b0, 1'b0);
        step(1'b1, 8'h02, 1'b0, 1'b0);
        step(1'b1, 8'h10, 1'b1, 1'b0);
        check("realign_dropped", 64'(dropped), 64'h2);
        check("realign_no_push", 64'(oenable), 64'h0);
        step(1'b1, 8'h20, 1'b0, 1'b0);
        step(1'b1, 8'h30, 1'b0, 1'b0);
        step(1'b1, 8'h40, 1'b0, 1'b0);
        check("realign_oenable", 64'(oenable), 64'h1);
        check("realign_odata", 64'(odata), 64'h40302010);
        check("realign_ogap", 64'(ogap), 64'h1);
        idle();

        // Saturation on the 2-bit counter; 16-bit counter keeps counting.
        resetn = 1'b0;
        #2;
        resetn = 1'b1;
        idle();
        check("sat_start", 64'(s_dropped), 64'h0);
        word(32'h01010101, 1'b1);
        check("sat_1", 64'(s_dropped), 64'h1);
        word(32'h02020202, 1'b1);
        check("sat_2", 64'(s_dropped), 64'h2);
        word(32'h03030303, 1'b1);
        check("sat_3", 64'(s_dropped), 64'h3);
        word(32'h04040404, 1'b1);
        check("sat_4", 64'(s_dropped), 64'h3);
        word(32'h05050505, 1'b1);
        check("sat_5", 64'(s_dropped), 64'h3);
        check("wide_5", 64'(dropped), 64'h5);
        check("sat_no_push", 64'(s_oenable), 64'h0);
        idle();

        // Reset mid-word leaves no trace.
        word(32'h0D0C0B0A, 1'b0);
        check("pre_rst_push", 64'(oenable), 64'h1);
        step(1'b1, 8'h55, 1'b0, 1'b0);
        step(1'b1, 8'h66, 1'b0, 1'b0);
        resetn = 1'b0;
        #1;
        check("midrst_odata", 64'(odata), 64'h0);
        check("midrst_ogap", 64'(ogap), 64'h0);
        check("midrst_oenable", 64'(oenable), 64'h0);
        check("midrst_dropped", 64'(dropped), 64'h0);
        @(posedge wclock);
        #1;
        resetn = 1'b1;
        idle();
        word(32'h44332211, 1'b0);
        check("postrst_oenable", 64'(oenable), 64'h1);
        check("postrst_odata", 64'(odata), 64'h44332211);
        check("postrst_ogap", 64'(ogap), 64'h0);
        check("postrst_dropped", 64'(dropped), 64'h0);
        idle();

        // Almost-full still high from FIFO reset drops the first word.
        resetn = 1'b0;
        #2;
        resetn = 1'b1;
        idle();
        word(32'h44332211, 1'b1);
        check("rst_af_no_push", 64'(oenable), 64'h0);
        check("rst_af_dropped", 64'(dropped), 64'h1);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
